// File: rtl/class_key_ser.sv
// class_key_ser: feeder for classifier lookup port A.
// Accepts one full-width key per handshake and serializes it as three beats
// on lu_vld/lu_key. Keeps an in-order tag FIFO so each lu_done result can be
// returned with its caller tag. The outstanding-lookup count limits how many
// keys can be in flight.
module class_key_ser #(
    parameter int BUS_WIDTH = 128,
    parameter int KEY_LEN   = 276,
    parameter int VT_AWIDTH = 16,
    parameter int TAG_W     = 8,
    parameter int MAX_OUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_vld,
    output logic                       key_rdy,
    input  logic [KEY_LEN-1:0]         key,
    input  logic [TAG_W-1:0]           key_tag,
    output logic                       lu_vld,
    output logic [BUS_WIDTH-1:0]       lu_key,
    input  logic                       lu_done,
    input  logic                       lu_err,
    input  logic                       lu_hit_miss,
    input  logic [VT_AWIDTH-1:0]       lu_vid,
    output logic                       rslt_vld,
    output logic [TAG_W-1:0]           rslt_tag,
    output logic                       rslt_err,
    output logic                       rslt_hit_miss,
    output logic [VT_AWIDTH-1:0]       rslt_vid,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int REM_W = KEY_LEN - 2 * BUS_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [KEY_LEN-1:0]     key_q;
    logic [KEY_LEN-1:0]     key_nxt;
    logic                   lu_vld_d;
    logic [BUS_WIDTH-1:0]   lu_key_d;
    logic [BUS_WIDTH-1:0]   tail_beat;
    logic [TAG_W-1:0]       tag_mem [MAX_OUT];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   accept;
    logic                   pop;

    // A key may only be taken between lookups and while a credit is free.
    assign key_rdy = ((state == IDLE) || (state == GAP)) &&
                     (outstanding < CNT_W'(MAX_OUT));
    assign accept  = key_vld && key_rdy;
    // A done with nothing outstanding is an underflow, never a pop.
    assign pop     = lu_done && (outstanding != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: beats run unconditionally once a key is accepted.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? B0 : IDLE;
            B0:      state_nxt = B1;
            B1:      state_nxt = B2;
            B2:      state_nxt = GAP;
            GAP:     state_nxt = accept ? B0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat selection for the upcoming state, so lu_vld/lu_key leave a flop.
    always_comb begin
        key_nxt   = accept ? key : key_q;
        tail_beat = '0;
        tail_beat[BUS_WIDTH-1 -: REM_W] = key_nxt[REM_W-1:0];
        lu_vld_d  = 1'b0;
        lu_key_d  = '0;
        case (state_nxt)
            B0: begin
                lu_vld_d = 1'b1;
                lu_key_d = key_nxt[KEY_LEN-1 -: BUS_WIDTH];
            end
            B1:      lu_key_d = key_nxt[KEY_LEN-BUS_WIDTH-1 -: BUS_WIDTH];
            B2:      lu_key_d = tail_beat;
            default: lu_key_d = '0;
        endcase
    end

    // Lookup bus output registers; reset drops any partially sent key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_vld <= 1'b0;
            lu_key <= '0;
        end else begin
            lu_vld <= lu_vld_d;
            lu_key <= lu_key_d;
        end
    end

    // Captured key held for the three beats.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q <= key;
        end
    end

    // Tag FIFO storage; cannot overflow because key_rdy tracks credits.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= key_tag;
        end
    end

    // FIFO pointers, credit count and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (lu_done && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Tagged result: one-cycle pulse carrying the FIFO head and result fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rslt_vld      <= 1'b0;
            rslt_tag      <= '0;
            rslt_err      <= 1'b0;
            rslt_hit_miss <= 1'b0;
            rslt_vid      <= '0;
        end else begin
            rslt_vld <= pop;
            if (pop) begin
                rslt_tag      <= tag_mem[rd_ptr];
                rslt_err      <= lu_err;
                rslt_hit_miss <= lu_hit_miss;
                rslt_vid      <= lu_vid;
            end
        end
    end

endmodule

// File: tb/tb_class_key_ser.sv
// Directed bench for class_key_ser with default parameters.
module tb_class_key_ser;

    localparam int BUS_WIDTH = 128;
    localparam int KEY_LEN   = 276;
    localparam int VT_AWIDTH = 16;
    localparam int TAG_W     = 8;
    localparam int MAX_OUT   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     key_vld;
    logic                     key_rdy;
    logic [KEY_LEN-1:0]       key;
    logic [TAG_W-1:0]         key_tag;
    logic                     lu_vld;
    logic [BUS_WIDTH-1:0]     lu_key;
    logic                     lu_done;
    logic                     lu_err;
    logic                     lu_hit_miss;
    logic [VT_AWIDTH-1:0]     lu_vid;
    logic                     rslt_vld;
    logic [TAG_W-1:0]         rslt_tag;
    logic                     rslt_err;
    logic                     rslt_hit_miss;
    logic [VT_AWIDTH-1:0]     rslt_vid;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic                     err_underflow;

    int n_pass = 0;
    int n_tot  = 0;

    class_key_ser #(
        .BUS_WIDTH (BUS_WIDTH),
        .KEY_LEN   (KEY_LEN),
        .VT_AWIDTH (VT_AWIDTH),
        .TAG_W     (TAG_W),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_vld       (key_vld),
        .key_rdy       (key_rdy),
        .key           (key),
        .key_tag       (key_tag),
        .lu_vld        (lu_vld),
        .lu_key        (lu_key),
        .lu_done       (lu_done),
        .lu_err        (lu_err),
        .lu_hit_miss   (lu_hit_miss),
        .lu_vid        (lu_vid),
        .rslt_vld      (rslt_vld),
        .rslt_tag      (rslt_tag),
        .rslt_err      (rslt_err),
        .rslt_hit_miss (rslt_hit_miss),
        .rslt_vid      (rslt_vid),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a key, wait (bounded) for key_rdy, and return right after the accepting edge.
    task automatic send(input logic [TAG_W-1:0] t, input logic [KEY_LEN-1:0] k);
        int n;
        n       = 0;
        key_tag = t;
        key     = k;
        key_vld = 1'b1;
        while (!key_rdy && n < 16) begin
            step();
            n++;
        end
        chk("send_rdy_wait", 128'(n < 16), 128'd1);
        step();
        key_vld = 1'b0;
    endtask

    initial begin
        logic [KEY_LEN-1:0] k1;
        k1          = {{32{4'hA}}, {32{4'hB}}, 20'hCCCCC};
        rst_n       = 1'b0;
        key_vld     = 1'b0;
        key         = '0;
        key_tag     = '0;
        lu_done     = 1'b0;
        lu_err      = 1'b0;
        lu_hit_miss = 1'b0;
        lu_vid      = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state.
        chk("rst_key_rdy", 128'(key_rdy), 128'd1);
        chk("rst_lu_vld", 128'(lu_vld), 128'd0);
        chk("rst_lu_key", 128'(lu_key), 128'd0);
        chk("rst_rslt_vld", 128'(rslt_vld), 128'd0);
        chk("rst_rslt_tag", 128'(rslt_tag), 128'd0);
        chk("rst_rslt_vid", 128'(rslt_vid), 128'd0);
        chk("rst_outstanding", 128'(outstanding), 128'd0);
        chk("rst_underflow", 128'(err_underflow), 128'd0);
        step();

        // Single lookup: three beats then GAP.
        send(8'h5A, k1);
        chk("s_b0_vld", 128'(lu_vld), 128'd1);
        chk("s_b0_key", 128'(lu_key), {32{4'hA}});
        chk("s_b0_rdy", 128'(key_rdy), 128'd0);
        chk("s_out1", 128'(outstanding), 128'd1);
        step();
        chk("s_b1_vld", 128'(lu_vld), 128'd0);
        chk("s_b1_key", 128'(lu_key), {32{4'hB}});
        chk("s_b1_rdy", 128'(key_rdy), 128'd0);
        step();
        chk("s_b2_vld", 128'(lu_vld), 128'd0);
        chk("s_b2_key", 128'(lu_key), {20'hCCCCC, 108'h0});
        chk("s_b2_rdy", 128'(key_rdy), 128'd0);
        step();
        chk("s_gap_vld", 128'(lu_vld), 128'd0);
        chk("s_gap_key", 128'(lu_key), 128'd0);
        chk("s_gap_rdy", 128'(key_rdy), 128'd1);

        // Result for the single lookup.
        lu_done     = 1'b1;
        lu_vid      = 16'h0123;
        lu_hit_miss = 1'b1;
        step();
        lu_done     = 1'b0;
        lu_hit_miss = 1'b0;
        chk("s_rslt_vld", 128'(rslt_vld), 128'd1);
        chk("s_rslt_tag", 128'(rslt_tag), 128'h5A);
        chk("s_rslt_vid", 128'(rslt_vid), 128'h0123);
        chk("s_rslt_hit", 128'(rslt_hit_miss), 128'd1);
        chk("s_rslt_err", 128'(rslt_err), 128'd0);
        chk("s_out0", 128'(outstanding), 128'd0);
        step();
        chk("s_rslt_pulse", 128'(rslt_vld), 128'd0);

        // Back-to-back: key_vld held, beat0 strobes every 4 cycles.
        key     = k1;
        key_tag = 8'd1;
        key_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("b2b_strobe", 128'(lu_vld), 128'((c % 4 == 0) && (c <= 16)));
            if ((c % 4 == 0) && (c < 16)) key_tag = 8'(c / 4 + 2);
            if (c == 16) key_vld = 1'b0;
        end
        chk("b2b_out5", 128'(outstanding), 128'd5);

        // Sustained lu_done every cycle; tags come back in order.
        lu_done = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("b2b_rslt_vld", 128'(rslt_vld), 128'd1);
            chk("b2b_rslt_tag", 128'(rslt_tag), 128'(i));
        end
        lu_done = 1'b0;
        step();
        chk("b2b_drained", 128'(outstanding), 128'd0);
        chk("b2b_rslt_idle", 128'(rslt_vld), 128'd0);

        // Credit limit: 16 accepts, across FIFO pointer wrap.
        for (int i = 0; i < 16; i++) begin
            send(8'(i), k1 ^ KEY_LEN'(i));
        end
        step();
        step();
        step();
        chk("cr_out16", 128'(outstanding), 128'd16);
        chk("cr_rdy_low", 128'(key_rdy), 128'd0);
        lu_done = 1'b1;
        lu_vid  = 16'hBEEF;
        step();
        chk("cr_out15", 128'(outstanding), 128'd15);
        chk("cr_rdy_high", 128'(key_rdy), 128'd1);
        chk("cr_tag0", 128'(rslt_tag), 128'd0);
        chk("cr_vid", 128'(rslt_vid), 128'hBEEF);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("cr_rslt_vld", 128'(rslt_vld), 128'd1);
            chk("cr_tag_order", 128'(rslt_tag), 128'(i));
        end
        lu_done = 1'b0;
        step();
        chk("cr_drained", 128'(outstanding), 128'd0);

        // Simultaneous accept and done with three outstanding.
        send(8'h30, k1);
        send(8'h31, k1);
        send(8'h32, k1);
        step();
        step();
        step();
        chk("sim_rdy", 128'(key_rdy), 128'd1);
        key_tag = 8'h33;
        key_vld = 1'b1;
        lu_done = 1'b1;
        lu_err  = 1'b1;
        step();
        key_vld = 1'b0;
        lu_err  = 1'b0;
        chk("sim_out3", 128'(outstanding), 128'd3);
        chk("sim_rslt_vld", 128'(rslt_vld), 128'd1);
        chk("sim_oldest_tag", 128'(rslt_tag), 128'h30);
        chk("sim_err", 128'(rslt_err), 128'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("sim_drain_tag", 128'(rslt_tag), 128'(8'h30 + i));
            chk("sim_drain_err", 128'(rslt_err), 128'd0);
        end
        lu_done = 1'b0;
        step();
        chk("sim_drained", 128'(outstanding), 128'd0);

        // Underflow: done with nothing outstanding.
        lu_done = 1'b1;
        step();
        lu_done = 1'b0;
        chk("uf_flag", 128'(err_underflow), 128'd1);
        chk("uf_no_rslt", 128'(rslt_vld), 128'd0);
        chk("uf_out0", 128'(outstanding), 128'd0);
        step();
        step();
        step();
        chk("uf_sticky", 128'(err_underflow), 128'd1);

        // Reset during beat1.
        send(8'h77, k1);
        step();
        chk("rm_in_b1", 128'(lu_key), {32{4'hB}});
        rst_n = 1'b0;
        step();
        chk("rm_lu_vld", 128'(lu_vld), 128'd0);
        chk("rm_lu_key", 128'(lu_key), 128'd0);
        chk("rm_out0", 128'(outstanding), 128'd0);
        chk("rm_rdy", 128'(key_rdy), 128'd1);
        chk("rm_uf_clr", 128'(err_underflow), 128'd0);
        rst_n = 1'b1;
        step();
        chk("rm_no_b2_key", 128'(lu_key), 128'd0);
        chk("rm_no_b2_vld", 128'(lu_vld), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
